// File: rtl/boot_rom_fetcher.sv
// Boot ROM read initiator: fetches a run of words over a UNICAD-style port with
// 1-cycle read latency and streams them out through a small FIFO with a running checksum.
module boot_rom_fetcher #(
   parameter int ROM_ADDR_WIDTH = 13,
   parameter int FIFO_DEPTH     = 4
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   input  logic                      start_i,
   input  logic [ROM_ADDR_WIDTH-3:0] base_i,
   input  logic [ROM_ADDR_WIDTH-2:0] len_i,
   input  logic                      abort_i,
   output logic                      busy_o,
   output logic                      done_o,
   output logic [31:0]               checksum_o,
   output logic                      mem_csn_o,
   output logic [31:0]               mem_add_o,
   output logic                      mem_wen_o,
   output logic [3:0]                mem_be_o,
   output logic [31:0]               mem_wdata_o,
   input  logic [31:0]               mem_rdata_i,
   output logic                      out_valid_o,
   input  logic                      out_ready_i,
   output logic [31:0]               out_data_o,
   output logic [1:0]                dbg_state_o
);

   localparam int WI = ROM_ADDR_WIDTH - 2;
   localparam int LW = ROM_ADDR_WIDTH - 1;
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam int OW = CW + 2;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   state_e        state_q, state_d;
   logic          csn_q, csn_d;
   logic [WI-1:0] add_q, add_d;
   logic [WI-1:0] idx_q, idx_d;
   logic [LW-1:0] rem_q, rem_d;
   logic          rvalid_q, rvalid_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [31:0]   fifo_q [FIFO_DEPTH];
   logic [31:0]   fifo_d [FIFO_DEPTH];
   logic [31:0]   sum_q, sum_d;

   logic          push, pop, issue, flush, can_issue;
   logic [OW-1:0] occ;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   // Stream handshake: a word moves when out_valid_o && out_ready_i at a rising edge;
   // out_valid_o never drops and out_data_o never changes while a word waits for ready.
   always_comb begin
      state_d   = state_q;
      csn_d     = 1'b1;
      add_d     = add_q;
      idx_d     = idx_q;
      rem_d     = rem_q;
      rvalid_d  = 1'b0;
      cnt_d     = cnt_q;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      fifo_d    = fifo_q;
      sum_d     = sum_q;
      issue     = 1'b0;
      flush     = 1'b0;
      push      = rvalid_q;
      pop       = (cnt_q != '0) && out_ready_i;
      // Words already owned (buffered, on rdata, requested) after this edge's pop.
      occ       = OW'(cnt_q) + OW'(rvalid_q) + OW'(!csn_q) - OW'(pop);
      can_issue = occ < OW'(FIFO_DEPTH);

      case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               sum_d = '0;
               if (len_i != '0) begin
                  issue   = 1'b1;
                  add_d   = base_i;
                  idx_d   = base_i + WI'(1);
                  rem_d   = len_i - LW'(1);
                  state_d = ST_FETCH;
               end else begin
                  state_d = ST_DONE;
               end
            end
         end
         ST_FETCH: begin
            if (abort_i) begin
               flush   = 1'b1;
               state_d = ST_IDLE;
            end else if (rem_q == '0) begin
               state_d = ST_DRAIN;
            end else if (can_issue) begin
               issue = 1'b1;
               add_d = idx_q;
               idx_d = idx_q + WI'(1);
               rem_d = rem_q - LW'(1);
               if (rem_q == LW'(1)) begin
                  state_d = ST_DRAIN;
               end
            end
         end
         ST_DRAIN: begin
            if (abort_i) begin
               flush   = 1'b1;
               state_d = ST_IDLE;
            end else if (csn_q && !rvalid_q &&
                         ((cnt_q == '0) || ((cnt_q == CW'(1)) && pop))) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            flush   = abort_i;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      if (flush) begin
         cnt_d    = '0;
         wr_ptr_d = '0;
         rd_ptr_d = '0;
      end else begin
         csn_d    = !issue;
         rvalid_d = !csn_q;
         if (push) begin
            fifo_d[wr_ptr_q] = mem_rdata_i;
            wr_ptr_d         = ptr_inc(wr_ptr_q);
         end
         if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
            sum_d    = sum_q + fifo_q[rd_ptr_q];
         end
         cnt_d = cnt_q + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= ST_IDLE;
         csn_q    <= 1'b1;
         add_q    <= '0;
         idx_q    <= '0;
         rem_q    <= '0;
         rvalid_q <= 1'b0;
         cnt_q    <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         sum_q    <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            fifo_q[i] <= '0;
         end
      end else begin
         state_q  <= state_d;
         csn_q    <= csn_d;
         add_q    <= add_d;
         idx_q    <= idx_d;
         rem_q    <= rem_d;
         rvalid_q <= rvalid_d;
         cnt_q    <= cnt_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         sum_q    <= sum_d;
         fifo_q   <= fifo_d;
      end
   end

   assign busy_o      = (state_q != ST_IDLE);
   assign done_o      = (state_q == ST_DONE);
   assign checksum_o  = sum_q;
   assign mem_csn_o   = csn_q;
   assign mem_add_o   = {{(32 - ROM_ADDR_WIDTH){1'b0}}, add_q, 2'b00};
   assign mem_wen_o   = 1'b1;
   assign mem_be_o    = 4'hF;
   assign mem_wdata_o = '0;
   assign out_valid_o = (cnt_q != '0);
   assign out_data_o  = fifo_q[rd_ptr_q];
   assign dbg_state_o = state_q;

endmodule
